// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: LEGv8 immediate generator with a one-cycle output register
// and a single skid entry, so the block streams one word per cycle while the
// consumer is ready and still absorbs one extra word on a stall.
// Optional macro IMM_GEN_BYTE_OFFSET_EN: when defined, CB and B immediates
// are returned as byte offsets (word offset shifted left by 2).
module imm_gen_pipe #(
   parameter int W    = 64,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [31:0]     instr,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [W-1:0]    imm,
   output logic [2:0]      fmt,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [CNTW-1:0] none_cnt
);

   localparam logic [2:0] FMT_NONE = 3'd0;
   localparam logic [2:0] FMT_D    = 3'd1;
   localparam logic [2:0] FMT_CB   = 3'd2;
   localparam logic [2:0] FMT_B    = 3'd3;
   localparam logic [2:0] FMT_I    = 3'd4;

   logic [W-1:0]    dec_imm;
   logic [2:0]      dec_fmt;

   logic [W-1:0]    out_imm_reg,   out_imm_next;
   logic [2:0]      out_fmt_reg,   out_fmt_next;
   logic            out_valid_reg, out_valid_next;
   logic [W-1:0]    skid_imm_reg,  skid_imm_next;
   logic [2:0]      skid_fmt_reg,  skid_fmt_next;
   logic            skid_valid_reg, skid_valid_next;
   logic            in_ready_reg,  in_ready_next;
   logic [CNTW-1:0] none_cnt_reg,  none_cnt_next;

   logic            in_fire;
   logic            out_fire;

   // Decode the incoming word; formats are tested in priority order.
   always_comb begin
      dec_imm = '0;
      dec_fmt = FMT_NONE;
      if (instr[31:21] == 11'b11111000010 || instr[31:21] == 11'b11111000000) begin
         dec_fmt = FMT_D;
         dec_imm = {{(W-9){instr[20]}}, instr[20:12]};
      end else if (instr[31:24] == 8'b10110100 || instr[31:24] == 8'b10110101) begin
         dec_fmt = FMT_CB;
`ifdef IMM_GEN_BYTE_OFFSET_EN
         dec_imm = {{(W-21){instr[23]}}, instr[23:5], 2'b00};
`else
         dec_imm = {{(W-19){instr[23]}}, instr[23:5]};
`endif
      end else if (instr[31:26] == 6'b000101) begin
         dec_fmt = FMT_B;
`ifdef IMM_GEN_BYTE_OFFSET_EN
         dec_imm = {{(W-28){instr[25]}}, instr[25:0], 2'b00};
`else
         dec_imm = {{(W-26){instr[25]}}, instr[25:0]};
`endif
      end else if (instr[31:22] == 10'b1001000100 || instr[31:22] == 10'b1101000100) begin
         dec_fmt = FMT_I;
         dec_imm = {{(W-12){1'b0}}, instr[21:10]};
      end
   end

   assign in_fire  = in_valid && in_ready_reg;
   assign out_fire = out_valid_reg && out_ready;

   // Output register / skid steering, ready generation and NONE counting.
   always_comb begin
      out_imm_next    = out_imm_reg;
      out_fmt_next    = out_fmt_reg;
      out_valid_next  = out_valid_reg;
      skid_imm_next   = skid_imm_reg;
      skid_fmt_next   = skid_fmt_reg;
      skid_valid_next = skid_valid_reg;
      none_cnt_next   = none_cnt_reg;

      if (!out_valid_reg || out_fire) begin
         // Output slot frees up: the older skid word has priority. in_ready is
         // low whenever the skid is full, so no new word can arrive then.
         if (skid_valid_reg) begin
            out_imm_next    = skid_imm_reg;
            out_fmt_next    = skid_fmt_reg;
            out_valid_next  = 1'b1;
            skid_valid_next = 1'b0;
         end else if (in_fire) begin
            out_imm_next   = dec_imm;
            out_fmt_next   = dec_fmt;
            out_valid_next = 1'b1;
         end else begin
            out_valid_next = 1'b0;
         end
      end else if (in_fire) begin
         // Output stalled: park the new word in the skid entry.
         skid_imm_next   = dec_imm;
         skid_fmt_next   = dec_fmt;
         skid_valid_next = 1'b1;
      end

      in_ready_next = !skid_valid_next;

      if (in_fire && dec_fmt == FMT_NONE && none_cnt_reg != {CNTW{1'b1}})
         none_cnt_next = none_cnt_reg + CNTW'(1);
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         out_imm_reg    <= '0;
         out_fmt_reg    <= FMT_NONE;
         out_valid_reg  <= 1'b0;
         skid_imm_reg   <= '0;
         skid_fmt_reg   <= FMT_NONE;
         skid_valid_reg <= 1'b0;
         in_ready_reg   <= 1'b0;
         none_cnt_reg   <= '0;
      end else begin
         out_imm_reg    <= out_imm_next;
         out_fmt_reg    <= out_fmt_next;
         out_valid_reg  <= out_valid_next;
         skid_imm_reg   <= skid_imm_next;
         skid_fmt_reg   <= skid_fmt_next;
         skid_valid_reg <= skid_valid_next;
         in_ready_reg   <= in_ready_next;
         none_cnt_reg   <= none_cnt_next;
      end
   end

   assign in_ready  = in_ready_reg;
   assign imm       = out_imm_reg;
   assign fmt       = out_fmt_reg;
   assign out_valid = out_valid_reg;
   assign none_cnt  = none_cnt_reg;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: table of known decodes, hand-written
// backpressure / streaming / reset / saturation sequences, and randomized
// traffic checked against a queue-based reference model.
module tb_imm_gen_pipe;

   logic        clk;
   logic        reset;
   logic [31:0] instr;
   logic        in_valid;
   logic        out_ready;

   logic        in_ready,  in_ready_s;
   logic [63:0] imm,       imm_s;
   logic [2:0]  fmt,       fmt_s;
   logic        out_valid, out_valid_s;
   logic [15:0] none_cnt;
   logic [3:0]  none_cnt_s;

   int checks = 0;
   int errors = 0;

   imm_gen_pipe #(.W(64), .CNTW(16)) dut (
      .clk(clk), .reset(reset), .instr(instr), .in_valid(in_valid),
      .in_ready(in_ready), .imm(imm), .fmt(fmt), .out_valid(out_valid),
      .out_ready(out_ready), .none_cnt(none_cnt)
   );

   imm_gen_pipe #(.W(64), .CNTW(4)) dut_sat (
      .clk(clk), .reset(reset), .instr(instr), .in_valid(in_valid),
      .in_ready(in_ready_s), .imm(imm_s), .fmt(fmt_s), .out_valid(out_valid_s),
      .out_ready(out_ready), .none_cnt(none_cnt_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [63:0] imm;
      logic [2:0]  fmt;
   } res_t;

   res_t   q[$];
   longint m_cnt  = 0;
   bit     m_rdy  = 1'b0;
   bit     m_zero = 1'b1;

   function automatic res_t ref_decode(input logic [31:0] w);
      res_t   r;
      longint v;
      r.imm = 64'd0;
      r.fmt = 3'd0;
      if (w[31:21] == 11'b11111000010 || w[31:21] == 11'b11111000000) begin
         v = longint'(w[20:12]);
         if (v >= 256) v = v - 512;
         r.fmt = 3'd1; r.imm = v;
      end else if (w[31:25] == 7'b1011010) begin
         v = longint'(w[23:5]);
         if (v >= 262144) v = v - 524288;
`ifdef IMM_GEN_BYTE_OFFSET_EN
         v = v * 4;
`endif
         r.fmt = 3'd2; r.imm = v;
      end else if (w[31:26] == 6'b000101) begin
         v = longint'(w[25:0]);
         if (v >= 33554432) v = v - 67108864;
`ifdef IMM_GEN_BYTE_OFFSET_EN
         v = v * 4;
`endif
         r.fmt = 3'd3; r.imm = v;
      end else if (w[31:22] == 10'b1001000100 || w[31:22] == 10'b1101000100) begin
         v = longint'(w[21:10]);
         r.fmt = 3'd4; r.imm = v;
      end
      return r;
   endfunction

   task automatic model_update();
      res_t r;
      bit   acc, dlv;
      if (!reset) begin
         q.delete();
         m_cnt  = 0;
         m_rdy  = 1'b0;
         m_zero = 1'b1;
      end else begin
         acc = in_valid && m_rdy;
         dlv = (q.size() > 0) && out_ready;
         if (dlv) begin
            r = q.pop_front();
            $display("xfer out imm=%h fmt=%0d", r.imm, r.fmt);
         end
         if (acc) begin
            r = ref_decode(instr);
            q.push_back(r);
            m_zero = 1'b0;
            if (r.fmt == 3'd0) m_cnt++;
         end
         m_rdy = (q.size() < 2);
      end
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic compare();
      longint e16, e4;
      e16 = (m_cnt > 65535) ? 65535 : m_cnt;
      e4  = (m_cnt > 15) ? 15 : m_cnt;
      chk("in_ready",     64'(in_ready),    64'(m_rdy));
      chk("out_valid",    64'(out_valid),   64'(q.size() > 0));
      chk("none_cnt",     64'(none_cnt),    e16);
      chk("none_cnt_sat", 64'(none_cnt_s),  e4);
      if (q.size() > 0) begin
         chk("imm", imm, q[0].imm);
         chk("fmt", 64'(fmt), 64'(q[0].fmt));
      end else if (m_zero) begin
         chk("imm_rst", imm, 64'd0);
         chk("fmt_rst", 64'(fmt), 64'd0);
      end
   endtask

   // One clock: model advances on the edge, DUT is compared at the falling edge.
   task automatic cycle();
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare();
   endtask

   // ---------------- table vectors ----------------
   typedef struct {
      logic [31:0] instr;
      logic [63:0] imm;
      logic [2:0]  fmt;
   } vec_t;

   vec_t tbl[12];

   initial begin
      res_t  r;
      logic [31:0] w;
      int    cls;

      tbl[0]  = '{32'hF84A9F02, 64'h00000000000000A9, 3'd1};
      tbl[1]  = '{32'hF85A9F01, 64'hFFFFFFFFFFFFFFA9, 3'd1};
      tbl[2]  = '{32'hF80A9F02, 64'h00000000000000A9, 3'd1};
`ifdef IMM_GEN_BYTE_OFFSET_EN
      tbl[3]  = '{32'hB40A9F01, 64'h00000000000153E0, 3'd2};
      tbl[4]  = '{32'hB48A9F01, 64'hFFFFFFFFFFF153E0, 3'd2};
      tbl[5]  = '{32'hB5000020, 64'h0000000000000004, 3'd2};
      tbl[6]  = '{32'h17FFFFFF, 64'hFFFFFFFFFFFFFFFC, 3'd3};
      tbl[7]  = '{32'h14000001, 64'h0000000000000004, 3'd3};
`else
      tbl[3]  = '{32'hB40A9F01, 64'h00000000000054F8, 3'd2};
      tbl[4]  = '{32'hB48A9F01, 64'hFFFFFFFFFFFC54F8, 3'd2};
      tbl[5]  = '{32'hB5000020, 64'h0000000000000001, 3'd2};
      tbl[6]  = '{32'h17FFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd3};
      tbl[7]  = '{32'h14000001, 64'h0000000000000001, 3'd3};
`endif
      tbl[8]  = '{32'h91001401, 64'h0000000000000005, 3'd4};
      tbl[9]  = '{32'hD1001401, 64'h0000000000000005, 3'd4};
      tbl[10] = '{32'h913FFC00, 64'h0000000000000FFF, 3'd4};
      tbl[11] = '{32'h550A9F01, 64'h0000000000000000, 3'd0};

      // Reset state, then release.
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; instr = 32'h0;
      cycle();
      cycle();
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      reset = 1'b1;
      cycle();
      chk("rel_in_ready", 64'(in_ready), 64'd1);

      // Table: one word per cycle, each visible one cycle after acceptance.
      for (int i = 0; i < 12; i++) begin
         instr = tbl[i].instr; in_valid = 1'b1;
         cycle();
         chk("tbl_valid", 64'(out_valid), 64'd1);
         chk("tbl_imm", imm, tbl[i].imm);
         chk("tbl_fmt", 64'(fmt), 64'(tbl[i].fmt));
      end
      in_valid = 1'b0;
      cycle();

      // Backpressure: three offers with a stalled consumer.
      out_ready = 1'b0; in_valid = 1'b1; instr = 32'hF84A9F02;
      cycle();
      chk("bp_rdy1", 64'(in_ready), 64'd1);
      instr = 32'h91001401;
      cycle();
      chk("bp_rdy2", 64'(in_ready), 64'd0);
      instr = 32'hF85A9F01;
      cycle();
      chk("bp_rdy3", 64'(in_ready), 64'd0);
      chk("bp_hold_imm", imm, 64'h00000000000000A9);
      chk("bp_hold_fmt", 64'(fmt), 64'd1);
      out_ready = 1'b1;
      cycle();
      chk("bp_drain1", imm, 64'h0000000000000005);
      chk("bp_rdy_rise", 64'(in_ready), 64'd1);
      cycle();
      chk("bp_drain2", imm, 64'hFFFFFFFFFFFFFFA9);
      in_valid = 1'b0;
      cycle();
      chk("bp_empty", 64'(out_valid), 64'd0);

      // Streaming: 8 back-to-back words, 1-cycle latency each.
      for (int i = 0; i < 8; i++) begin
         instr = tbl[(i * 5) % 12].instr; in_valid = 1'b1;
         cycle();
         chk("stream_valid", 64'(out_valid), 64'd1);
         chk("stream_imm", imm, tbl[(i * 5) % 12].imm);
      end

      // Reset with two words buffered.
      out_ready = 1'b0; instr = 32'h550A9F01;
      cycle();
      cycle();
      reset = 1'b0; in_valid = 1'b0;
      cycle();
      chk("midrst_valid", 64'(out_valid), 64'd0);
      chk("midrst_cnt", 64'(none_cnt), 64'd0);
      reset = 1'b1; out_ready = 1'b1;
      cycle();

      // Saturation of the 4-bit counter instance.
      in_valid = 1'b1; instr = 32'h550A9F01;
      for (int i = 0; i < 20; i++) cycle();
      in_valid = 1'b0;
      cycle();
      chk("sat_cnt4", 64'(none_cnt_s), 64'hF);
      chk("sat_cnt16", 64'(none_cnt), 64'd20);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         w   = $urandom;
         cls = $urandom_range(0, 4);
         case (cls)
            0: w[31:21] = ($urandom_range(0, 1) != 0) ? 11'b11111000010 : 11'b11111000000;
            1: w[31:24] = ($urandom_range(0, 1) != 0) ? 8'b10110100 : 8'b10110101;
            2: w[31:26] = 6'b000101;
            3: w[31:22] = ($urandom_range(0, 1) != 0) ? 10'b1001000100 : 10'b1101000100;
            default: ;
         endcase
         instr     = w;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         reset     = ($urandom_range(0, 99) != 0);
         cycle();
      end
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      cycle();
      cycle();
      r = ref_decode(32'hF84A9F02);
      chk("ref_sanity", r.imm, 64'h00000000000000A9);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
